instruction_fetch_m: RTL
========================

Name: instruction_fetch_m

Overview:
Producer end of the instruction interface that the decoder, ALUControl and branch logic consume. Holds the program counter and requests words from a word-addressed instruction memory with variable latency. Presents one instruction at a time to the core with a valid/ready handshake. Redirects the PC on Uncondbranch, or on Branch with zeroflag, using the decoder's signed immediate.

Parameters:
ADDR_WIDTH, 32, PC and instruction-memory address width
RESET_PC, 0, PC loaded on reset; must be a multiple of 4
INSTR_WIDTH, 32, instruction word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory, level
imem_addr  output  ADDR_WIDTH  byte address of requested word
imem_ack  input  1  read data valid, one-cycle pulse
imem_rdata  input  INSTR_WIDTH  instruction word returned with imem_ack
instruction  output  INSTR_WIDTH  instruction to decoder/ALUControl
inst_pc  output  ADDR_WIDTH  address of the presented instruction
inst_valid  output  1  instruction/inst_pc are valid
inst_ready  input  1  core consumes the instruction this cycle
Uncondbranch  input  1  from decoder, sampled on handshake
Branch  input  1  from decoder, sampled on handshake
zeroflag  input  1  from ALU, sampled on handshake
immediate  input  32  signed word offset from decoder, sampled on handshake
fetch_count  output  32  number of instructions consumed

Behaviour:
- Reset is asynchronous and active-high. Reset values: pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=0, instruction=0, inst_pc=0, inst_valid=0, fetch_count=0.
- States: FETCH, WAIT, HOLD.
- FETCH, one cycle:
  - Register imem_req=1 and imem_addr=pc.
  - Go to WAIT.
- WAIT:
  - Hold imem_req=1 and imem_addr stable until imem_ack.
  - On imem_ack: register instruction=imem_rdata and inst_pc=pc, set inst_valid=1, drop imem_req=0, go to HOLD.
  - imem_ack is ignored in FETCH and HOLD.
  - Memory latency is at least 1 cycle after imem_req rises.
- HOLD:
  - inst_valid=1; instruction and inst_pc stay stable until the handshake.
  - Handshake is inst_valid && inst_ready. On handshake:
    - taken = Uncondbranch | (Branch & zeroflag).
    - If taken: pc <= inst_pc + (sign-extended immediate << 2), truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
    - Else: pc <= inst_pc + 4, also wrapping.
    - inst_valid <= 0; fetch_count <= fetch_count + 1 (wraps at 2^32); go to FETCH.
  - Without inst_ready: stay in HOLD; branch inputs are ignored.
- Throughput: one instruction per 3 cycles with 1-cycle memory latency and inst_ready tied high. Latency from reset release to first inst_valid is 3 cycles with 1-cycle memory.
- Branch inputs matter only on the handshake cycle. Uncondbranch takes priority; Branch without zeroflag falls through to pc+4.
- A negative immediate gives a backward target. For example, B #-1 at 0x8 gives 0x4.
- Reset mid-WAIT: the request is abandoned, imem_req drops at once, and no stale ack is accepted (memory shares the reset).
- Reset while in HOLD: the instruction is dropped without counting.
- imem_addr is always word-aligned by construction.

Decomposition:
- Shared package (legv8_pkg):
  - state encoding constants FETCH=2'd0, WAIT=2'd1, HOLD=2'd2
  - INSTR_WIDTH
  - BRANCH_SHIFT=2
- One natural sub-module: next_pc_m, combinational. Inputs inst_pc, immediate, Uncondbranch, Branch, zeroflag; output next PC. Reused later by a pipelined core.
- FSM and registers stay in instruction_fetch_m.

Test Plan:
- Reset release with a memory returning 0x91002021 at 0x0 after 1 cycle, inst_ready=1 → imem_addr=0x0. Third cycle after release: instruction=0x91002021, inst_pc=0x0, inst_valid=1. Next imem_addr=0x4 and fetch_count=1.
- Sequential run over 0xF8000041, 0xF8400043, 0xD1001C63 at 0x4/0x8/0xC, no branches → inst_pc sequence 0x4, 0x8, 0xC; fetch_count=4 after the last handshake.
- Instruction 0xB40000E3 (CBZ X3,#7) at 0xC, Branch=1, immediate=7: with zeroflag=1 next imem_addr=0x28; rerun with zeroflag=0 → next imem_addr=0x10.
- 0x17FFFFFF (B #-1) at 0x8, Uncondbranch=1, immediate=-1 → next imem_addr=0x4. With pc=0x0 and immediate=-1 → next imem_addr=0xFFFFFFFC (wrap).
- inst_ready=0 for 5 cycles while in HOLD, with Branch=1 and zeroflag=1 toggling → instruction, inst_pc and inst_valid stay stable, fetch_count unchanged, no redirect. On ready, redirect uses the handshake-cycle values only.
- Assert reset mid-WAIT (imem_req=1) and deliver imem_ack in the same cycle → outputs return to reset values immediately. After release the fetch restarts at RESET_PC and no instruction is presented from the dropped ack.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 front end.
//   state_t      : fetch FSM encoding (FETCH, WAIT, HOLD)
//   INSTR_WIDTH  : instruction word width
//   BRANCH_SHIFT : word offset -> byte offset shift for branch immediates
package legv8_pkg;

   localparam int INSTR_WIDTH  = 32;
   localparam int BRANCH_SHIFT = 2;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/next_pc_m.sv
// Next program counter computation (purely combinational).
//   inst_pc      : address of the instruction being retired
//   immediate    : signed word offset from the decoder
//   Uncondbranch : unconditional branch, always taken
//   Branch       : conditional branch, taken when zeroflag is set
//   zeroflag     : ALU zero result
//   next_pc      : branch target or fall-through (inst_pc + 4), wraps
module next_pc_m
   import legv8_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic [31:0]           immediate,
   input  logic                  Uncondbranch,
   input  logic                  Branch,
   input  logic                  zeroflag,
   output logic [ADDR_WIDTH-1:0] next_pc
);

   logic                  taken;
   logic [ADDR_WIDTH-1:0] offset;

   always_comb begin
      taken  = Uncondbranch | (Branch & zeroflag);
      // Sign-extend past ADDR_WIDTH before shifting so the word offset
      // becomes a byte offset that wraps modulo 2^ADDR_WIDTH.
      offset = ADDR_WIDTH'({{ADDR_WIDTH{immediate[31]}}, immediate} << BRANCH_SHIFT);
      if (taken) begin
         next_pc = inst_pc + offset;
      end else begin
         next_pc = inst_pc + ADDR_WIDTH'(4);
      end
   end

endmodule

// File: rtl/instruction_fetch_m.sv
// Instruction fetch unit: holds the PC, reads one word at a time from a
// variable-latency instruction memory and presents it to the core with a
// valid/ready handshake, redirecting the PC on taken branches.
//   clk, reset           : clock, asynchronous active-high reset
//   imem_req/imem_addr   : level read request and byte address of the word
//   imem_ack/imem_rdata  : one-cycle read-data pulse and the word
//   instruction/inst_pc  : presented instruction and its address
//   inst_valid/inst_ready: handshake to the core
//   Uncondbranch, Branch, zeroflag, immediate : branch info, sampled on handshake
//   fetch_count          : number of instructions consumed
module instruction_fetch_m #(
   parameter int          ADDR_WIDTH  = 32,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          INSTR_WIDTH = legv8_pkg::INSTR_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0]  inst_pc,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   input  logic                   Uncondbranch,
   input  logic                   Branch,
   input  logic                   zeroflag,
   input  logic [31:0]            immediate,
   output logic [31:0]            fetch_count
);

   import legv8_pkg::*;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic                   imem_req_q, imem_req_d;
   logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
   logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
   logic [ADDR_WIDTH-1:0]  inst_pc_q, inst_pc_d;
   logic                   inst_valid_q, inst_valid_d;
   logic [31:0]            fetch_count_q, fetch_count_d;
   logic [ADDR_WIDTH-1:0]  next_pc;

   next_pc_m #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_next_pc (
      .inst_pc      (inst_pc_q),
      .immediate    (immediate),
      .Uncondbranch (Uncondbranch),
      .Branch       (Branch),
      .zeroflag     (zeroflag),
      .next_pc      (next_pc)
   );

   always_comb begin
      // NOTE: every signal gets a hold-value default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      imem_req_d    = imem_req_q;
      imem_addr_d   = imem_addr_q;
      instruction_d = instruction_q;
      inst_pc_d     = inst_pc_q;
      inst_valid_d  = inst_valid_q;
      fetch_count_d = fetch_count_q;

      case (state_q)
         FETCH: begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
            state_d     = WAIT;
         end
         WAIT: begin
            // Request and address are held until the memory answers.
            if (imem_ack) begin
               instruction_d = imem_rdata;
               inst_pc_d     = pc_q;
               inst_valid_d  = 1'b1;
               imem_req_d    = 1'b0;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            // Branch inputs only matter on the handshake cycle itself.
            if (inst_valid_q && inst_ready) begin
               pc_d          = next_pc;
               inst_valid_d  = 1'b0;
               fetch_count_d = fetch_count_q + 32'd1;
               state_d       = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= FETCH;
         pc_q          <= ADDR_WIDTH'(RESET_PC);
         imem_req_q    <= 1'b0;
         imem_addr_q   <= '0;
         instruction_q <= '0;
         inst_pc_q     <= '0;
         inst_valid_q  <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q       <= state_d;
         pc_q          <= pc_d;
         imem_req_q    <= imem_req_d;
         imem_addr_q   <= imem_addr_d;
         instruction_q <= instruction_d;
         inst_pc_q     <= inst_pc_d;
         inst_valid_q  <= inst_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign instruction = instruction_q;
   assign inst_pc     = inst_pc_q;
   assign inst_valid  = inst_valid_q;
   assign fetch_count = fetch_count_q;

endmodule
